// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (CPU/IOP) arbiter for the single synchronous word memory.
// Ports:
//   i_clock, i_reset              clock (rising edge), asynchronous active-low reset
//   i_cpu_* / i_iop_*             per-master request, word address, byte write enables, write data
//   o_cpu_grant, o_iop_grant      registered one-hot bus ownership
//   o_cpu_rvalid, o_iop_rvalid    memory read data belongs to that master this cycle
//   o_memory_*                    address, byte write enables and write data to the Memory block
module mem_bus_arbiter #(
    parameter int unsigned MAX_HOLD    = 8,
    parameter bit          RESET_OWNER = 1'b1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_cpu_req,
    input  logic [15:31] i_cpu_address,
    input  logic [0:3]   i_cpu_write_en,
    input  logic [0:31]  i_cpu_data,
    input  logic         i_iop_req,
    input  logic [15:31] i_iop_address,
    input  logic [0:3]   i_iop_write_en,
    input  logic [0:31]  i_iop_data,
    output logic         o_cpu_grant,
    output logic         o_iop_grant,
    output logic         o_cpu_rvalid,
    output logic         o_iop_rvalid,
    output logic [15:31] o_memory_address,
    output logic [0:3]   o_memory_write_en,
    output logic [0:31]  o_memory_data_in
);
    typedef enum logic {OWN_CPU = 1'b0, OWN_IOP = 1'b1} state_t;
    localparam state_t     RESET_STATE = RESET_OWNER ? OWN_IOP : OWN_CPU;
    localparam logic [7:0] HOLD_LAST   = 8'(MAX_HOLD - 1);
    state_t     r_state, w_next;
    logic [7:0] r_hold, w_hold;
    logic       r_cpu_rvalid, r_iop_rvalid;
    logic       w_cpu_own, w_own_req, w_oth_req;
    assign w_cpu_own = (r_state == OWN_CPU);
    assign w_own_req = w_cpu_own ? i_cpu_req : i_iop_req;
    assign w_oth_req = w_cpu_own ? i_iop_req : i_cpu_req;
    // Owner keeps the bus while it still requests and has not used up its hold
    // budget; otherwise a waiting master takes over. The bus parks on the last owner.
    always_comb begin
        w_next = r_state;
        w_hold = 8'd0;
        if (w_oth_req && w_own_req && r_hold != HOLD_LAST)
            w_hold = r_hold + 8'd1;
        else if (w_oth_req)
            w_next = w_cpu_own ? OWN_IOP : OWN_CPU;
    end
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= RESET_STATE;
            r_hold       <= 8'd0;
            r_cpu_rvalid <= 1'b0;
            r_iop_rvalid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_hold       <= w_hold;
            // Memory reads are synchronous, so the result appears one cycle after the read edge.
            r_cpu_rvalid <= w_cpu_own & i_cpu_req & ~|i_cpu_write_en;
            r_iop_rvalid <= ~w_cpu_own & i_iop_req & ~|i_iop_write_en;
        end
    end
    assign o_cpu_grant       = w_cpu_own;
    assign o_iop_grant       = ~w_cpu_own;
    assign o_cpu_rvalid      = r_cpu_rvalid;
    assign o_iop_rvalid      = r_iop_rvalid;
    assign o_memory_address  = w_cpu_own ? i_cpu_address : i_iop_address;
    assign o_memory_data_in  = w_cpu_own ? i_cpu_data : i_iop_data;
    // An idle owner must not write, and a non-owner is never routed to memory.
    assign o_memory_write_en = !w_own_req ? 4'b0000 : w_cpu_own ? i_cpu_write_en : i_iop_write_en;
endmodule
